// File: rtl/uart_pkg.sv
// Shared encodings and line levels for the buffered UART transmitter.
// The PARITY state is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam int   DATA_BITS   = 8;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte write handshake between the debug message generator and the UART transmitter.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] tx_data;
  logic                 new_tx_data;
  logic                 tx_busy;

  modport master (output tx_data, output new_tx_data, input tx_busy);
  modport slave  (input tx_data, input new_tx_data, output tx_busy);

endinterface

// File: rtl/uart_tx_buffered_fifo.sv
// Synchronous FIFO (module sync_fifo) with a separate occupancy counter so that full and empty
// are distinguishable with naturally wrapping pointers. Storage is never cleared.
module sync_fifo #(
  parameter int DATA_W    = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic [ADDR_BITS:0] count,
  output logic              full,
  output logic              empty
);

  localparam int DEPTH = 2**ADDR_BITS;

  logic [DATA_W-1:0]    mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wptr_q, wptr_d;
  logic [ADDR_BITS-1:0] rptr_q, rptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 do_push, do_pop;

  assign full  = (count_q == (ADDR_BITS+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign dout  = mem_q[rptr_q];
  assign count = count_q;

  // A push while full is dropped even when a pop happens in the same cycle.
  always_comb begin
    do_push = push && !full;
    do_pop  = pop && !empty;
    wptr_d  = wptr_q + ADDR_BITS'(do_push);
    rptr_d  = rptr_q + ADDR_BITS'(do_pop);
    count_d = count_q + (ADDR_BITS+1)'(do_push) - (ADDR_BITS+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queues bytes in sync_fifo and sends 8N1 frames, LSB first,
// pausing between frames while block is high. Define UART_TX_PARITY_EN for 8E1 framing.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 100,
  parameter int ADDR_BITS   = 4
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_buffered_if.slave   wr,
  input  logic                block,
  output logic                tx,
  output logic [ADDR_BITS:0]  fifo_count,
  output logic                overflow
);

  localparam int                TICK_W    = $clog2(CLK_PER_BIT);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]        BIT_LAST  = 3'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [2:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 pop, start_next, tick_last;
  logic                 fifo_full, fifo_empty;
  logic [DATA_BITS-1:0] fifo_dout;

  sync_fifo #(
    .DATA_W    (DATA_BITS),
    .ADDR_BITS (ADDR_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr.new_tx_data),
    .pop   (pop),
    .din   (wr.tx_data),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wr.tx_busy = fifo_full;
  assign tx         = tx_q;
  assign overflow   = overflow_q;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    pop        = 1'b0;
    tick_last  = (tick_q == TICK_LAST);
    start_next = !fifo_empty && !block;
    overflow_d = overflow_q | (wr.new_tx_data & fifo_full);

    case (state_q)
      IDLE: begin
        if (start_next) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          tick_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick_last) begin
          tick_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA: begin
        if (tick_last) begin
          tick_d = '0;
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (tick_last) begin
          tick_d  = '0;
          state_d = STOP;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
`endif
      STOP: begin
        // Back-to-back frames: the next byte is popped on the last stop cycle.
        if (tick_last) begin
          tick_d = '0;
          if (start_next) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = START_LEVEL;
      DATA:    tx_d = shreg_d[bit_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = ^shreg_d;
`endif
      default: tx_d = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      bit_q      <= '0;
      tx_q       <= IDLE_LEVEL;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_q      <= bit_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: queue/frame-position reference model compared
// every cycle, plus directed literal checks. Honours UART_TX_PARITY_EN.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int AB    = 4;
  localparam int DEPTH = 2**AB;
`ifdef UART_TX_PARITY_EN
  localparam int SLOTS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int SLOTS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int FRAME = SLOTS * CPB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          block = 1'b0;
  logic          tx;
  logic [AB:0]   fifo_count;
  logic          overflow;

  uart_tx_buffered_if wr_if ();

  uart_tx_buffered #(
    .CLK_PER_BIT (CPB),
    .ADDR_BITS   (AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (wr_if.slave),
    .block      (block),
    .tx         (tx),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the position inside the current frame.
  logic [7:0] mq[$];
  bit         m_ovf   = 1'b0;
  int         m_pos   = -1;
  logic [7:0] m_cur   = 8'h00;
  bit         m_tx    = 1'b1;
  bit         m_ready = 1'b0;

  function automatic bit frame_bit(input logic [7:0] b, input int pos);
    int slot;
    slot = pos / CPB;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
    if (PAR && slot == 9) return ^b;
    return 1'b1;
  endfunction

  initial begin
    bit was_full, decide;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        m_ovf   = 1'b0;
        m_pos   = -1;
        m_tx    = 1'b1;
        m_ready = 1'b1;
      end else if (m_ready) begin
        was_full = (mq.size() == DEPTH);
        decide   = (m_pos == -1 || m_pos == FRAME-1) && (mq.size() != 0) && !block;
        if (decide) begin
          m_cur = mq.pop_front();
          m_pos = 0;
        end else if (m_pos == FRAME-1) begin
          m_pos = -1;
        end else if (m_pos >= 0) begin
          m_pos++;
        end
        if (wr_if.new_tx_data) begin
          if (was_full) m_ovf = 1'b1;
          else          mq.push_back(wr_if.tx_data);
        end
        m_tx = (m_pos < 0) ? 1'b1 : frame_bit(m_cur, m_pos);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_ready) begin
        check("model_tx",       32'(tx),            32'(m_tx));
        check("model_count",    32'(fifo_count),    32'(mq.size()));
        check("model_tx_busy",  32'(wr_if.tx_busy), 32'(mq.size() == DEPTH));
        check("model_overflow", 32'(overflow),      32'(m_ovf));
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [7:0] d);
    wr_if.tx_data     = d;
    wr_if.new_tx_data = 1'b1;
    step();
    wr_if.new_tx_data = 1'b0;
  endtask

  initial begin
    bit exp_bits [8];
    exp_bits = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    wr_if.tx_data     = 8'h00;
    wr_if.new_tx_data = 1'b0;

    step(2);
    check("reset_tx",       32'(tx),            32'd1);
    check("reset_tx_busy",  32'(wr_if.tx_busy), 32'd0);
    check("reset_count",    32'(fifo_count),    32'd0);
    check("reset_overflow", 32'(overflow),      32'd0);
    rst = 1'b0;
    step(2);

    // Single byte 0x41: start bit two cycles after the strobe.
    write(8'h41);
    step();
    for (int k = 0; k < CPB; k++) begin
      check("single_start", 32'(tx), 32'd0);
      step();
    end
    for (int i = 0; i < 8; i++) begin
      check("single_data", 32'(tx), 32'(exp_bits[i]));
      step(CPB);
    end
    if (PAR) begin
      check("single_parity", 32'(tx), 32'd0);
      step(CPB);
    end
    check("single_stop", 32'(tx), 32'd1);
    step(CPB);
    check("single_idle_tx",    32'(tx),         32'd1);
    check("single_idle_count", 32'(fifo_count), 32'd0);

    if (PAR) begin
      write(8'h07);
      step(1 + 9*CPB);
      check("parity_07", 32'(tx), 32'd1);
      step(2*CPB);
    end

    // Fill while blocked, then overflow, then drain back to back.
    block = 1'b1;
    step();
    for (int i = 0; i < DEPTH; i++) write(8'($urandom));
    check("fill_count",    32'(fifo_count),    32'd16);
    check("fill_busy",     32'(wr_if.tx_busy), 32'd1);
    check("fill_overflow", 32'(overflow),      32'd0);
    write(8'hEE);
    check("drop_overflow", 32'(overflow),   32'd1);
    check("drop_count",    32'(fifo_count), 32'd16);
    block = 1'b0;
    step();
    check("drain_start_tx",    32'(tx),         32'd0);
    check("drain_start_count", 32'(fifo_count), 32'd15);
    step(DEPTH*FRAME - 1);
    check("drain_last_stop", 32'(tx),         32'd1);
    check("drain_end_count", 32'(fifo_count), 32'd0);
    step(2);

    // Block raised mid-frame: current frame completes, next one waits.
    write(8'h5A);
    write(8'hC3);
    step(12);
    block = 1'b1;
    step(FRAME);
    check("block_hold_tx",    32'(tx),         32'd1);
    check("block_hold_count", 32'(fifo_count), 32'd1);
    step(10);
    check("block_still_tx", 32'(tx), 32'd1);
    block = 1'b0;
    step();
    check("unblock_tx",    32'(tx),         32'd0);
    check("unblock_count", 32'(fifo_count), 32'd0);
    step(FRAME + 2);

    // Reset during data bit 3 with five bytes queued.
    for (int i = 0; i < 6; i++) write(8'($urandom));
    step(12);
    check("pre_reset_count", 32'(fifo_count), 32'd5);
    rst = 1'b1;
    step();
    check("midreset_tx",       32'(tx),            32'd1);
    check("midreset_count",    32'(fifo_count),    32'd0);
    check("midreset_overflow", 32'(overflow),      32'd0);
    check("midreset_busy",     32'(wr_if.tx_busy), 32'd0);
    rst = 1'b0;
    step(FRAME + 5);
    check("post_reset_tx", 32'(tx), 32'd1);

    // Random traffic with block toggling, overflows and rare resets.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) < 3) block = ~block;
      rst               = ($urandom_range(0, 1999) == 0);
      wr_if.tx_data     = 8'($urandom);
      wr_if.new_tx_data = ($urandom_range(0, 99) < ((i < 2000) ? 4 : 30));
      step();
    end
    rst               = 1'b0;
    block             = 1'b0;
    wr_if.new_tx_data = 1'b0;
    step(DEPTH*FRAME + 10);
    check("final_count", 32'(fifo_count), 32'd0);
    check("final_tx",    32'(tx),         32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Sits between the debug message generator and the serial line to the AVR.
- Accepts bytes on a strobe/busy handshake (tx_data/new_tx_data in, tx_busy out) and queues them in a FIFO sized for one full 16-byte debug message.
- Serializes the queued bytes as 8N1 UART frames, LSB first.
- Honours the AVR's block flow-control input at frame boundaries.

Parameters:
- CLK_PER_BIT, 100, clk cycles per UART bit (50 MHz / 500 kbaud); minimum 2.
- ADDR_BITS, 4, FIFO depth = 2**ADDR_BITS entries.

Ports:
- clk  in  1  system clock; one clock domain only.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to queue.
- new_tx_data  in  1  one-cycle write strobe for tx_data.
- tx_busy  out  1  FIFO full; upstream must not strobe while high.
- block  in  1  AVR flow control; already synchronous to clk; 1 = do not start a new frame.
- tx  out  1  serial output, registered, idle high.
- fifo_count  out  ADDR_BITS+1  current occupancy, 0..2**ADDR_BITS.
- overflow  out  1  sticky: a write was dropped; cleared only by rst.

Behaviour:
- Reset values: tx=1, tx_busy=0, fifo_count=0, overflow=0, state=IDLE, bit counter and tick counter=0. FIFO storage is not cleared.
- Reset mid-frame aborts the frame. tx=1 on the cycle after rst is sampled, and all queued bytes are discarded.
- Write: new_tx_data && !tx_busy pushes tx_data. fifo_count and tx_busy update the following cycle.
- Write while tx_busy=1 drops the byte and sets overflow, even if a pop occurs in the same cycle.
- Simultaneous push and pop with the FIFO not full: fifo_count is unchanged.
- tx_busy = (fifo_count == 2**ADDR_BITS), driven from registered state.
- Serializer states:
  - IDLE: tx=1. If fifo_count!=0 && !block: pop the head into the shift register and go to START.
  - START: tx=0 for CLK_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, CLK_PER_BIT cycles each. Bit index counts 0..7, then STOP.
  - STOP: tx=1 for CLK_PER_BIT cycles. On the last cycle of STOP:
    - if fifo_count!=0 && !block: pop and go directly to START (no idle gap between frames);
    - otherwise go to IDLE.
- Latency: a write in cycle N into an empty, idle block produces the tx falling edge at cycle N+2.
- Frame length is exactly 10*CLK_PER_BIT cycles.
- block is sampled only where a pop decision is made (IDLE, last STOP cycle). Asserting it mid-frame never truncates the current frame.
- Tick counter runs 0..CLK_PER_BIT-1 and wraps; its width is the ceiling of log2(CLK_PER_BIT).
- FIFO pointers are ADDR_BITS wide and wrap naturally. fifo_count is tracked separately to distinguish full from empty.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP.
  - Drives the even-parity bit (XOR of the 8 data bits) for CLK_PER_BIT cycles.
  - Frame becomes 11*CLK_PER_BIT cycles (8E1).
- Undefined: no PARITY state and no parity logic; 8N1 framing as above.

Decomposition:
- Shared package (uart_pkg): state encodings IDLE/START/DATA/PARITY/STOP, IDLE_LEVEL=1, START_LEVEL=0, DATA_BITS=8.
- One sub-module, sync_fifo:
  - Parameters: width 8 and ADDR_BITS.
  - Signals: push/pop, dout, count, full, empty.
  - Serializer FSM and tick counter stay in uart_tx_buffered.

Test Plan (CLK_PER_BIT=4, ADDR_BITS=4):
1. Reset: hold rst 2 cycles -> tx=1, tx_busy=0, fifo_count=0, overflow=0.
2. Single byte: write 0x41 at cycle N -> tx=0 over cycles N+2..N+5, then bits 1,0,0,0,0,0,1,0 for 4 cycles each, stop high. Frame ends after 40 cycles; fifo_count returns to 0.
3. Fill and overflow:
   - With block=1, write 16 bytes -> fifo_count=16, tx_busy=1.
   - 17th strobe -> dropped, overflow=1.
   - Release block -> 16 contiguous frames, 640 cycles, no idle cycles, bytes in write order.
4. Block mid-frame: 2 bytes queued, raise block during DATA of frame 1 -> frame 1 completes, tx stays 1, fifo_count=1. Drop block -> frame 2 starts the next cycle.
5. Reset mid-frame: rst during DATA bit 3 with 5 bytes queued -> tx=1 and fifo_count=0 the next cycle, overflow=0, no further frames.
6. UART_TX_PARITY_EN defined: 0x41 -> parity bit 0; 0x07 -> parity bit 1. Frame length 44 cycles.
